// File: rtl/led_sched_if.sv
// Control, table-load and LED-drive signals of the LED sequence scheduler.
// The master side drives the user controls; the slave side is the scheduler.
interface led_sched_if #(
    parameter int DWELL_W = 4
);
    logic               run;
    logic               step;
    logic               clear;
    logic               load_en;
    logic [1:0]         load_idx;
    logic [7:0]         load_pattern;
    logic [DWELL_W-1:0] load_dwell;
    logic [7:0]         LED_out;
    logic [1:0]         cur_idx;
    logic               cycle_done;

    modport master (
        output run, step, clear, load_en, load_idx, load_pattern, load_dwell,
        input  LED_out, cur_idx, cycle_done
    );

    modport slave (
        input  run, step, clear, load_en, load_idx, load_pattern, load_dwell,
        output LED_out, cur_idx, cycle_done
    );
endinterface

// File: rtl/led_sequence_scheduler.sv
// Steps the LED bank through a runtime-loadable 4-entry pattern table with
// per-entry dwell in prescaled ticks; supports run, pause, single-step and clear.
module led_sequence_scheduler #(
    parameter int TICK_DIV = 50000000,
    parameter int DWELL_W  = 4
) (
    input logic        clk,
    input logic        rst,
    led_sched_if.slave bus
);
    localparam int            PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic [7:0]         led_q, led_d;
    logic               cdone_q, cdone_d;
    logic [7:0]         pat_q   [4];
    logic [DWELL_W-1:0] dwell_q [4];
    logic [DWELL_W-1:0] dwell_lim;
    logic               tick;
    logic               advance;

    // Last dwell_cnt value of an entry; a programmed dwell of 0 behaves as 1.
    function automatic logic [DWELL_W-1:0] dwell_limit(input logic [DWELL_W-1:0] d);
        return (d == '0) ? '0 : d - DWELL_W'(1);
    endfunction

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        dwell_cnt_d = dwell_cnt_q;
        idx_d       = idx_q;
        cdone_d     = 1'b0;
        led_d       = 8'h00;
        advance     = 1'b0;
        tick        = (presc_q == PRESC_MAX);
        dwell_lim   = dwell_limit(dwell_q[idx_q]);

        case (state_q)
            ST_IDLE: begin
                presc_d     = '0;
                dwell_cnt_d = '0;
                idx_d       = '0;
                if (bus.run) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!bus.run) begin
                    state_d = ST_PAUSE;
                end else if (tick) begin
                    presc_d = '0;
                    // >= so a dwell shrunk below the current count still releases the entry
                    if (dwell_cnt_q >= dwell_lim) advance = 1'b1;
                    else dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            ST_PAUSE: begin
                if (bus.run) state_d = ST_RUN;
                else if (bus.step) advance = 1'b1;
            end
            default: begin
                state_d     = ST_IDLE;
                presc_d     = '0;
                dwell_cnt_d = '0;
                idx_d       = '0;
            end
        endcase

        if (advance) begin
            idx_d       = idx_q + 2'd1;
            dwell_cnt_d = '0;
            presc_d     = '0;
            cdone_d     = (idx_q == 2'd3);
        end

        if (bus.clear) begin
            state_d     = ST_IDLE;
            idx_d       = '0;
            presc_d     = '0;
            dwell_cnt_d = '0;
            cdone_d     = 1'b0;
        end

        if (state_q == ST_RUN || state_q == ST_PAUSE) led_d = pat_q[idx_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            dwell_cnt_q <= '0;
            idx_q       <= '0;
            led_q       <= 8'h00;
            cdone_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            dwell_cnt_q <= dwell_cnt_d;
            idx_q       <= idx_d;
            led_q       <= led_d;
            cdone_q     <= cdone_d;
        end
    end

    // Table writes are independent of the state machine, clear included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q[0]   <= 8'h0F;
            pat_q[1]   <= 8'h0A;
            pat_q[2]   <= 8'hA0;
            pat_q[3]   <= 8'hAA;
            dwell_q[0] <= DWELL_W'(1);
            dwell_q[1] <= DWELL_W'(1);
            dwell_q[2] <= DWELL_W'(1);
            dwell_q[3] <= DWELL_W'(1);
        end else if (bus.load_en) begin
            pat_q[bus.load_idx]   <= bus.load_pattern;
            dwell_q[bus.load_idx] <= bus.load_dwell;
        end
    end

    assign bus.LED_out    = led_q;
    assign bus.cur_idx    = idx_q;
    assign bus.cycle_done = cdone_q;
endmodule

// File: doc/led_sequence_scheduler.md
Name: led_sequence_scheduler

Overview:
- Programmable scheduler that drives the 8-bit LED bank through a 4-entry table of patterns.
- Each entry has its own dwell time, counted in prescaled ticks of clk.
- Sits between the board user inputs (run/step/clear switches, already debounced and synchronised) and the LED pins.
- Replaces the fixed one-second, four-state LED cycle with run/pause/single-step control and runtime table loading.

Parameters:
TICK_DIV, 50000000, clk cycles per dwell tick (1 s at 50 MHz); must be ≥2
DWELL_W, 4, width of each dwell entry in ticks

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst  input  1  asynchronous, active-high reset
run  input  1  level; 1 = sequence advances automatically, 0 = pause
step  input  1  single-cycle pulse; advances one entry while paused
clear  input  1  single-cycle pulse; synchronous return to IDLE
load_en  input  1  write strobe for table entry load_idx
load_idx  input  2  table entry to write
load_pattern  input  8  pattern written to entry
load_dwell  input  DWELL_W  dwell written to entry; 0 is treated as 1
LED_out  output  8  registered LED drive
cur_idx  output  2  current table index
cycle_done  output  1  one-cycle pulse when the index wraps from 3 to 0

Behaviour:
- Reset (async, rst=1):
  - State=IDLE, cur_idx=0, LED_out=8'h00, cycle_done=0, prescaler=0, dwell_cnt=0.
  - Table = {0:8'h0F, 1:8'h0A, 2:8'hA0, 3:8'hAA}, all dwells=1.
  - Reset mid-sequence discards all progress and any runtime loads.
- States: IDLE, RUN, PAUSE (2-bit encoding; unused code recovers to IDLE on the next clk).
- IDLE:
  - LED_out=0; prescaler and dwell_cnt held at 0; cur_idx=0.
  - run=1 -> RUN.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and wraps; tick=1 on the cycle the count equals TICK_DIV-1.
  - On tick: if dwell_cnt == eff_dwell(cur_idx)-1, then cur_idx++ (mod 4) and dwell_cnt=0; otherwise dwell_cnt++.
  - eff_dwell = max(dwell,1).
  - run=0 -> PAUSE; prescaler and dwell_cnt hold their values (no reset).
  - step is ignored.
- PAUSE:
  - Prescaler and dwell_cnt frozen.
  - step=1 -> cur_idx++ (mod 4), dwell_cnt=0, prescaler=0.
  - run=1 -> RUN. If run=1 and step=1 in the same cycle, the state goes to RUN and step is ignored.
- clear=1 in any state -> IDLE with cur_idx=0, counters=0 on the next edge. clear has priority over run and step.
- LED_out:
  - Registered: LED_out <= table_pattern[cur_idx] in RUN/PAUSE, 0 in IDLE.
  - One clk latency after a cur_idx change or a table write.
- cycle_done: asserted for exactly one cycle, coincident with the cur_idx 3->0 update, whether caused by tick or by step. Never asserted by clear or reset.
- Table writes:
  - load_en=1 writes the entry on the clock edge; accepted in every state, including alongside clear.
  - Writing the active entry takes effect immediately: the new pattern appears on LED_out one cycle later, and the new dwell is used in the compare from the next cycle.
  - If dwell_cnt ≥ new eff_dwell-1, the entry advances at the next tick (compare is ≥, not ==).
- Width rules:
  - Prescaler width = clog2(TICK_DIV); no overflow past TICK_DIV-1.
  - dwell_cnt is DWELL_W bits and never exceeds 2^DWELL_W-1.

Test Plan:
- Default sequence: TICK_DIV=4, rst pulse, run=1 -> LED_out 0F,0A,A0,AA,0F, each held 4 cycles; cycle_done pulses once at the AA->0F change.
- Dwell load: load entry 1 with pattern 8'h55, dwell 3, while IDLE, then run -> entry 1 shows 55 for 12 cycles; entry 0 dwell 0 lasts 4 cycles.
- Pause/step: run 0 mid-entry 2, hold 20 cycles -> LED_out stays A0. One step pulse -> AA next cycle. Step again -> 0F plus a cycle_done pulse. run=1 with step in the same cycle -> resumes, no extra advance.
- Clear priority: in RUN at entry 3, assert clear, run and load_en together -> IDLE, LED_out=0 next cycle; the table write is still applied (checked after rerun).
- Active-entry shrink: entry 0 dwell 8, wait 5 ticks, load dwell 2 to entry 0 -> advance to entry 1 on the next tick.
- Async reset mid-RUN: assert rst between clock edges -> LED_out=0 and cur_idx=0 immediately; loaded entries revert to defaults.
